// File: rtl/uart_pkg.sv
// Shared constants and FSM state encoding for the UART transmit path.
package uart_pkg;

    localparam int UART_FRAME_BITS = 9;
    localparam logic [UART_FRAME_BITS-1:0] UART_IDLE_FRAME = 9'h1FF;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_SEND      = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } tx_state_t;

    function automatic logic even_parity(input logic [7:0] data_byte);
        return ^data_byte;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Circular single-clock FIFO with array storage and registered read data.
module sync_fifo #(
    parameter int              WIDTH      = 8,
    parameter int              DEPTH_LOG2 = 4,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_reg;
    logic [DEPTH_LOG2-1:0] rd_ptr_reg;
    logic [DEPTH_LOG2:0]   count_reg;
    logic [WIDTH-1:0]      rd_data_reg;
    logic                  wr_ok;
    logic                  rd_ok;

    assign full  = (count_reg == (DEPTH_LOG2+1)'(DEPTH));
    assign empty = (count_reg == '0);
    assign count = count_reg;
    assign rd_data = rd_data_reg;

    // Full is judged before any same-cycle read frees a slot.
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            rd_data_reg <= RESET_DATA;
        end else begin
            if (wr_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr_reg  <= rd_ptr_reg + 1'b1;
                rd_data_reg <= mem[rd_ptr_reg];
            end
            case ({wr_ok, rd_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus frame sequencer feeding uart_transmitter via send/busy.
// Define UART_TX_FIFO_PARITY_EN for even parity in frame bit 8; otherwise bit 8 is a mark bit.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2   = 4,
    parameter int BUSY_TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [7:0]                 wr_data,
    input  logic                       wr_en,
    output logic                       full,
    output logic                       empty,
    output logic [DEPTH_LOG2:0]        count,
    output logic                       overflow,
    output logic [UART_FRAME_BITS-1:0] tx_data,
    output logic                       tx_send,
    input  logic                       tx_busy,
    output logic                       timeout
);

    localparam int TIMER_BITS = $clog2(BUSY_TIMEOUT + 1);

    tx_state_t                  state_reg;
    logic                       tx_send_reg;
    logic                       timeout_reg;
    logic                       overflow_reg;
    logic [TIMER_BITS-1:0]      timer_reg;
    logic                       frame_bit8;
    logic [UART_FRAME_BITS-1:0] wr_frame;
    logic                       fifo_rd_en;

`ifdef UART_TX_FIFO_PARITY_EN
    assign frame_bit8 = even_parity(wr_data);
`else
    assign frame_bit8 = 1'b1;
`endif

    // Frames are stored complete so the FIFO read register drives tx_data directly.
    assign wr_frame   = {frame_bit8, wr_data};
    assign fifo_rd_en = (state_reg == S_IDLE) && !empty;

    sync_fifo #(
        .WIDTH      (UART_FRAME_BITS),
        .DEPTH_LOG2 (DEPTH_LOG2),
        .RESET_DATA (UART_IDLE_FRAME)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (wr_frame),
        .rd_en   (fifo_rd_en),
        .rd_data (tx_data),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_reg <= 1'b0;
        end else if (wr_en && full) begin
            overflow_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            tx_send_reg <= 1'b0;
            timeout_reg <= 1'b0;
            timer_reg   <= '0;
        end else begin
            tx_send_reg <= 1'b0;
            timeout_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (!empty) begin
                        state_reg   <= S_SEND;
                        tx_send_reg <= 1'b1;
                    end
                end
                S_SEND: begin
                    state_reg <= S_WAIT_BUSY;
                    timer_reg <= '0;
                end
                S_WAIT_BUSY: begin
                    if (tx_busy) begin
                        state_reg <= S_WAIT_DONE;
                    end else if (timer_reg == TIMER_BITS'(BUSY_TIMEOUT - 1)) begin
                        // Transmitter never acknowledged: drop this frame and move on.
                        timeout_reg <= 1'b1;
                        state_reg   <= S_IDLE;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!tx_busy) begin
                        state_reg <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign tx_send  = tx_send_reg;
    assign timeout  = timeout_reg;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo with a simple transmitter busy model.
module tb_uart_tx_fifo;

    localparam int DEPTH_LOG2   = 4;
    localparam int BUSY_TIMEOUT = 64;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [7:0]            wr_data = 8'h00;
    logic                  wr_en = 1'b0;
    logic                  full;
    logic                  empty;
    logic [DEPTH_LOG2:0]   count;
    logic                  overflow;
    logic [8:0]            tx_data;
    logic                  tx_send;
    logic                  tx_busy = 1'b0;
    logic                  timeout;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [8:0] sent_q[$];

    // busy_mode: 0 = never busy, 1 = busy 3 cycles after send for busy_len_cfg cycles, 2 = held high
    int busy_mode = 0;
    int busy_len_cfg = 20;
    int busy_dly = 0;
    int busy_left = 0;

    uart_tx_fifo #(
        .DEPTH_LOG2   (DEPTH_LOG2),
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .tx_data  (tx_data),
        .tx_send  (tx_send),
        .tx_busy  (tx_busy),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (tx_send) begin
            sent_q.push_back(tx_data);
            $display("cycle %0d: frame sent tx_data=%h", cyc, tx_data);
        end
    end

    always @(posedge clk) begin
        #2;
        if (busy_left > 0) busy_left--;
        if (busy_dly > 0) begin
            busy_dly--;
            if (busy_dly == 0) busy_left = busy_len_cfg;
        end
        if (busy_mode == 1 && tx_send) busy_dly = 3;
        tx_busy = (busy_mode == 2) || (busy_mode == 1 && busy_left > 0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time %0t reached, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [8:0] exp_frame(input logic [7:0] b);
`ifdef UART_TX_FIFO_PARITY_EN
        return {^b, b};
`else
        return {1'b1, b};
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got %b want 1", empty); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full: got %b want 0", full); end
        total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        total++; if (tx_data !== 9'h1FF) begin bad++; $display("FAIL reset_tx_data: got %h want 1ff", tx_data); end
        total++; if (tx_send !== 1'b0) begin bad++; $display("FAIL reset_tx_send: got %b want 0", tx_send); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout: got %b want 0", timeout); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_frame();
        sent_q.delete();
        busy_len_cfg = 20;
        busy_mode = 1;
        wr_data = 8'h55;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        total++; if (tx_send !== 1'b0) begin bad++; $display("FAIL single_send_early: got %b want 0", tx_send); end
        total++; if (empty !== 1'b0) begin bad++; $display("FAIL single_not_empty: got %b want 0", empty); end
        tick();
        total++; if (tx_send !== 1'b1) begin bad++; $display("FAIL single_send_latency: got %b want 1", tx_send); end
        total++; if (tx_data !== exp_frame(8'h55)) begin bad++; $display("FAIL single_tx_data: got %h want %h", tx_data, exp_frame(8'h55)); end
        tick();
        total++; if (tx_send !== 1'b0) begin bad++; $display("FAIL single_send_pulse: got %b want 0", tx_send); end
        repeat (40) tick();
        total++; if (sent_q.size() !== 1) begin bad++; $display("FAIL single_send_count: got %0d want 1", sent_q.size()); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL single_empty_after: got %b want 1", empty); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL single_timeout: got %b want 0", timeout); end
    endtask

    task automatic test_burst_overflow();
        int w;
        logic [8:0] expv;
        sent_q.delete();
        busy_len_cfg = 4;
        busy_mode = 2;
        wr_data = 8'hAA;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        repeat (4) tick();
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL burst_prime_popped: got empty=%b want 1", empty); end
        for (int i = 0; i < 16; i++) begin
            wr_data = 8'(i);
            wr_en = 1'b1;
            tick();
        end
        wr_en = 1'b0;
        total++; if (full !== 1'b1) begin bad++; $display("FAIL burst_full: got %b want 1", full); end
        total++; if (count !== 5'd16) begin bad++; $display("FAIL burst_count: got %0d want 16", count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL burst_no_overflow_yet: got %b want 0", overflow); end
        wr_data = 8'h10;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL burst_overflow: got %b want 1", overflow); end
        total++; if (count !== 5'd16) begin bad++; $display("FAIL burst_count_after_drop: got %0d want 16", count); end
        busy_mode = 1;
        w = 0;
        while (sent_q.size() < 17 && w < 1000) begin tick(); w++; end
        repeat (12) tick();
        total++; if (sent_q.size() !== 17) begin bad++; $display("FAIL burst_frame_count: got %0d want 17", sent_q.size()); end
        for (int i = 0; i < sent_q.size() && i < 17; i++) begin
            expv = (i == 0) ? exp_frame(8'hAA) : exp_frame(8'(i - 1));
            total++; if (sent_q[i] !== expv) begin bad++; $display("FAIL burst_order[%0d]: got %h want %h", i, sent_q[i], expv); end
        end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL burst_drained: got empty=%b want 1", empty); end
    endtask

    task automatic test_same_cycle_wrap();
        int nxt;
        int guard;
        sent_q.delete();
        busy_len_cfg = 2;
        busy_mode = 2;
        for (int i = 0; i < 6; i++) begin
            wr_data = 8'(128 + i);
            wr_en = 1'b1;
            tick();
        end
        wr_en = 1'b0;
        repeat (4) tick();
        total++; if (count !== 5'd5) begin bad++; $display("FAIL same_pre_count: got %0d want 5", count); end
        busy_mode = 1;
        tick();
        wr_data = 8'(128 + 6);
        wr_en = 1'b1;
        total++; if (count !== 5'd5) begin bad++; $display("FAIL same_count_before_edge: got %0d want 5", count); end
        tick();
        wr_en = 1'b0;
        total++; if (count !== 5'd5) begin bad++; $display("FAIL same_count_held: got %0d want 5", count); end
        total++; if (tx_send !== 1'b1) begin bad++; $display("FAIL same_read_happened: got tx_send=%b want 1", tx_send); end
        nxt = 7;
        guard = 0;
        while (nxt < 40 && guard < 800) begin
            if (!full) begin
                wr_data = 8'(128 + nxt);
                wr_en = 1'b1;
                nxt++;
            end else begin
                wr_en = 1'b0;
            end
            tick();
            guard++;
        end
        wr_en = 1'b0;
        total++; if (nxt !== 40) begin bad++; $display("FAIL same_writes_done: got %0d want 40", nxt); end
        guard = 0;
        while (sent_q.size() < 40 && guard < 1000) begin tick(); guard++; end
        repeat (10) tick();
        total++; if (sent_q.size() !== 40) begin bad++; $display("FAIL same_frame_count: got %0d want 40", sent_q.size()); end
        for (int i = 0; i < sent_q.size() && i < 40; i++) begin
            total++; if (sent_q[i] !== exp_frame(8'(128 + i))) begin bad++; $display("FAIL same_order[%0d]: got %h want %h", i, sent_q[i], exp_frame(8'(128 + i))); end
        end
    endtask

    task automatic test_timeout();
        int w;
        busy_mode = 0;
        wr_data = 8'hC3;
        wr_en = 1'b1;
        tick();
        wr_data = 8'h3C;
        tick();
        wr_en = 1'b0;
        w = 0;
        while (tx_send !== 1'b1 && w < 10) begin tick(); w++; end
        total++; if (tx_send !== 1'b1) begin bad++; $display("FAIL timeout_first_send: got %b want 1", tx_send); end
        total++; if (tx_data !== exp_frame(8'hC3)) begin bad++; $display("FAIL timeout_first_data: got %h want %h", tx_data, exp_frame(8'hC3)); end
        repeat (64) tick();
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL timeout_early: got %b want 0", timeout); end
        tick();
        total++; if (timeout !== 1'b1) begin bad++; $display("FAIL timeout_pulse: got %b want 1", timeout); end
        tick();
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL timeout_one_cycle: got %b want 0", timeout); end
        total++; if (tx_send !== 1'b1) begin bad++; $display("FAIL timeout_next_send: got %b want 1", tx_send); end
        total++; if (tx_data !== exp_frame(8'h3C)) begin bad++; $display("FAIL timeout_next_data: got %h want %h", tx_data, exp_frame(8'h3C)); end
        repeat (80) tick();
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL timeout_empty_after: got %b want 1", empty); end
    endtask

    task automatic test_reset_mid_frame();
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL mid_overflow_sticky: got %b want 1", overflow); end
        busy_mode = 2;
        for (int i = 0; i < 4; i++) begin
            wr_data = 8'(224 + i);
            wr_en = 1'b1;
            tick();
        end
        wr_en = 1'b0;
        repeat (4) tick();
        total++; if (count !== 5'd3) begin bad++; $display("FAIL mid_queued: got %0d want 3", count); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL mid_empty: got %b want 1", empty); end
        total++; if (count !== 5'd0) begin bad++; $display("FAIL mid_count: got %0d want 0", count); end
        total++; if (tx_send !== 1'b0) begin bad++; $display("FAIL mid_tx_send: got %b want 0", tx_send); end
        total++; if (tx_data !== 9'h1FF) begin bad++; $display("FAIL mid_tx_data: got %h want 1ff", tx_data); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL mid_overflow: got %b want 0", overflow); end
        wr_data = 8'h5A;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        tick();
        total++; if (tx_send !== 1'b1) begin bad++; $display("FAIL mid_idle_after_reset: got tx_send=%b want 1", tx_send); end
        total++; if (tx_data !== exp_frame(8'h5A)) begin bad++; $display("FAIL mid_data_after_reset: got %h want %h", tx_data, exp_frame(8'h5A)); end
        busy_mode = 0;
        repeat (4) tick();
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_burst_overflow();
        test_same_cycle_wrap();
        test_timeout();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
